// File: rtl/pwl_seg_select.sv
// Piecewise-linear segment selector.
// Compares a sign-magnitude sample against NBP ascending breakpoints and
// returns the segment index plus that segment's slope and intercept.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_data        sample input handshake
//   out_valid/out_ready              result output handshake
//   out_m, out_c, out_seg            selected slope, intercept, segment
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata  table write port (0=bp,1=m,2=c)
//   cfg_ready                        pipeline empty, writes allowed
//   cfg_err                          sticky illegal-write flag
module pwl_seg_select #(
  parameter int unsigned W   = 32,
  parameter int unsigned NBP = 8,
  localparam int unsigned SW = $clog2(NBP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_m,
  output logic [W-1:0]  out_c,
  output logic [SW-1:0] out_seg,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [5:0]    cfg_addr,
  input  logic [W-1:0]  cfg_wdata,
  output logic          cfg_ready,
  output logic          cfg_err
);

  logic [W-1:0]   r_bp [NBP];
  logic [W-1:0]   r_m  [NBP+1];
  logic [W-1:0]   r_c  [NBP+1];

  logic           r_s1_valid;
  logic [NBP-1:0] r_s1_flags;
  logic           r_out_valid;
  logic [SW-1:0]  r_seg;
  logic [W-1:0]   r_m_out;
  logic [W-1:0]   r_c_out;
  logic           r_cfg_err;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_accept;
  logic [NBP-1:0] w_flags;
  logic [SW-1:0]  w_seg;
  logic [W-1:0]   w_m_sel;
  logic [W-1:0]   w_c_sel;
  logic           w_cfg_ready;
  logic           w_addr_bad;
  logic           w_cfg_wr;
  logic           w_cfg_illegal;

  // Sign-magnitude a < b; -0 is normalised to +0 so the two compare equal.
  function automatic logic sm_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] am;
    logic [W-2:0] bm;
    logic         a_neg;
    logic         b_neg;
    am    = a[W-2:0];
    bm    = b[W-2:0];
    a_neg = a[W-1] & (|am);
    b_neg = b[W-1] & (|bm);
    if (a_neg != b_neg) return a_neg;
    else if (a_neg)     return am > bm;
    else                return am < bm;
  endfunction

  // Handshake: S2 frees when empty or drained; S1 frees when empty or S2 moves.
  assign w_s2_adv = !r_out_valid | out_ready;
  assign w_s1_adv = !r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv & !cfg_we;
  assign w_accept = in_valid & in_ready;

  // All breakpoint comparisons in parallel.
  always_comb begin
    w_flags = '0;
    for (int i = 0; i < int'(NBP); i++) begin
      w_flags[i] = sm_lt(in_data, r_bp[i]);
    end
  end

  // Lowest set flag wins; no flag means the sample is above every breakpoint.
  always_comb begin
    w_seg = SW'(NBP);
    for (int i = int'(NBP) - 1; i >= 0; i--) begin
      if (r_s1_flags[i]) w_seg = SW'(i);
    end
  end

  // Coefficient lookup for the chosen segment.
  always_comb begin
    w_m_sel = '0;
    w_c_sel = '0;
    for (int k = 0; k <= int'(NBP); k++) begin
      if (w_seg == SW'(k)) begin
        w_m_sel = r_m[k];
        w_c_sel = r_c[k];
      end
    end
  end

  // Pipeline stage 1: flag vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_flags <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_flags <= w_flags;
    end
  end

  // Pipeline stage 2: registered outputs, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_seg       <= '0;
      r_m_out     <= '0;
      r_c_out     <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_seg   <= w_seg;
        r_m_out <= w_m_sel;
        r_c_out <= w_c_sel;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_seg   = r_seg;
  assign out_m     = r_m_out;
  assign out_c     = r_c_out;

  // Table writes only with the pipeline empty so no sample sees a half-updated table.
  assign w_cfg_ready = !r_s1_valid & !r_out_valid & !in_valid;
  assign cfg_ready   = w_cfg_ready;

  always_comb begin
    w_addr_bad = 1'b1;
    case (cfg_sel)
      2'd0:    w_addr_bad = ({1'b0, cfg_addr} >= 7'(NBP));
      2'd1,
      2'd2:    w_addr_bad = ({1'b0, cfg_addr} >  7'(NBP));
      default: w_addr_bad = 1'b1;
    endcase
  end

  assign w_cfg_wr      = cfg_we & w_cfg_ready & !w_addr_bad;
  assign w_cfg_illegal = cfg_we & !w_cfg_wr;

  // Coefficient and breakpoint tables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NBP); i++)  r_bp[i] <= '0;
      for (int k = 0; k <= int'(NBP); k++) begin
        r_m[k] <= '0;
        r_c[k] <= '0;
      end
    end else if (w_cfg_wr) begin
      for (int i = 0; i < int'(NBP); i++) begin
        if (cfg_sel == 2'd0 && cfg_addr == 6'(i)) r_bp[i] <= cfg_wdata;
      end
      for (int k = 0; k <= int'(NBP); k++) begin
        if (cfg_sel == 2'd1 && cfg_addr == 6'(k)) r_m[k] <= cfg_wdata;
        if (cfg_sel == 2'd2 && cfg_addr == 6'(k)) r_c[k] <= cfg_wdata;
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cfg_err <= 1'b0;
    else if (w_cfg_illegal) r_cfg_err <= 1'b1;
  end

  assign cfg_err = r_cfg_err;

endmodule

// File: doc/pwl_seg_select.md
PWL_SEG_SELECT -- requirements
Module: pwl_seg_select

Interface
REQ-001 SHALL have parameter W, default 32: data, breakpoint, slope and intercept width; sign-magnitude format, bit W-1 is the sign.
REQ-002 SHALL have parameter NBP, default 8, range 1..32: breakpoint count; segment count is NBP+1.
REQ-003 SHALL have localparam SW = clog2(NBP+1): segment-index width.
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous assert, active low.
REQ-006 SHALL have port in_valid  in  1: in_data is valid.
REQ-007 SHALL have port in_ready  out  1: block accepts in_data this cycle.
REQ-008 SHALL have port in_data  in  W: sample.
REQ-009 SHALL have port out_valid  out  1: out_m, out_c and out_seg are valid.
REQ-010 SHALL have port out_ready  in  1: downstream accepts the result.
REQ-011 SHALL have port out_m  out  W: selected slope.
REQ-012 SHALL have port out_c  out  W: selected intercept.
REQ-013 SHALL have port out_seg  out  SW: selected segment index, 0..NBP.
REQ-014 SHALL have port cfg_we  in  1: table write strobe.
REQ-015 SHALL have port cfg_sel  in  2: write target; 0 = breakpoint, 1 = slope, 2 = intercept, 3 = reserved.
REQ-016 SHALL have port cfg_addr  in  6: table entry index.
REQ-017 SHALL have port cfg_wdata  in  W: write data.
REQ-018 SHALL have port cfg_ready  out  1: pipeline empty, so table writes are permitted.
REQ-019 SHALL have port cfg_err  out  1: sticky flag for an illegal write.

Function
REQ-020 SHALL hold internal registered tables: bp[0..NBP-1], m[0..NBP] and c[0..NBP].
REQ-021 SHALL rely on software to load bp in ascending signed order; the block SHALL NOT check this ordering.
REQ-022 SHALL compare values in sign-magnitude: if signs differ, the negative value is smaller; if both are positive, the larger magnitude is larger; if both are negative, the larger magnitude is smaller.
REQ-023 SHALL treat -0 and +0 as equal in every comparison.
REQ-024 SHALL compute flag[i] = (in_data < bp[i]) for every i in parallel.
REQ-025 SHALL set seg to the lowest i for which flag[i]=1; if no flag is set, seg SHALL be NBP.
REQ-026 SHALL note that data equal to bp[i] therefore selects segment i+1.
REQ-027 SHALL implement a two-stage pipeline: S1 registers the sample and flag vector; S2 registers seg, m[seg] and c[seg] to the outputs.
REQ-028 SHALL have a latency of exactly 2 cycles from an in_valid&in_ready edge to out_valid, when not stalled.
REQ-029 SHALL sustain a throughput of one sample per cycle while out_ready=1.
REQ-030 SHALL advance S2 when !out_valid | out_ready.
REQ-031 SHALL advance S1 when !s1_valid | (S2 advances).
REQ-032 SHALL drive in_ready = (S1 may load) & !cfg_we.
REQ-033 SHALL keep out_m, out_c and out_seg stable while out_valid=1 & out_ready=0.
REQ-034 SHALL assert no combinational path from out_ready to out_valid.
REQ-035 SHALL drive cfg_ready = !s1_valid & !out_valid & !in_valid.
REQ-036 SHALL write the table entry at the clock edge when cfg_we & cfg_ready; the new value is visible to the next accepted sample.
REQ-037 SHALL treat a write as illegal, ignore it and set cfg_err when cfg_we=1 and any of: cfg_ready=0, cfg_sel=3, cfg_addr>=NBP for a breakpoint, or cfg_addr>NBP for a slope or intercept.
REQ-038 SHALL clear cfg_err only by reset.
REQ-039 SHALL block sample acceptance while cfg_we=1, so a write and an acceptance never happen in the same cycle.

Reset
REQ-040 SHALL, while rst_n=0, force out_valid=0, the internal S1 valid=0, out_m=0, out_c=0, out_seg=0, cfg_err=0, and all bp, m and c entries to 0.
REQ-041 SHALL discard any in-flight samples when reset asserts mid-operation.
REQ-042 SHALL produce cfg_ready=1 after reset, given in_valid=0.
REQ-043 SHALL begin operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-044 SHALL cover: NBP=8, bp={-3.0,-2.0,-1.0,-0.5,0.5,1.0,2.0,3.0} (IEEE-754 bit patterns), m[k]=k, c[k]=16+k; in_data=0.0 -> two cycles later out_seg=4, out_m=4, out_c=20.
REQ-045 SHALL cover: in_data=-5.0 -> out_seg=0; in_data=+7.0 -> out_seg=8; in_data=bp[4] exactly -> out_seg=5.
REQ-046 SHALL cover: bp[3]=+0 and in_data=0x80000000 (-0) -> treated as equal to bp[3] -> out_seg=4.
REQ-047 SHALL cover: stream 10 samples with out_ready toggled 1,0,0,1,... -> all 10 results arrive in order, with no loss or duplication and outputs held during stalls.
REQ-048 SHALL cover: cfg_we with a sample in flight, then cfg_sel=3, then cfg_addr=9 for a slope -> each write ignored, cfg_err=1 from the first one, table unchanged.
REQ-049 SHALL cover: rst_n pulsed low while two samples are in flight -> out_valid=0 immediately, no stale result after release, all table entries read back as 0 through the datapath.
